frame_fifo_unpacker: RTL and testbench

FRAME_FIFO_UNPACKER -- requirements
Module: frame_fifo_unpacker

---
 rtl/frame_fifo_unpacker.sv | 172 +++++++++++++++++
 tb/tb_frame_fifo_unpacker.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_fifo_unpacker.sv
// frame_fifo_unpacker
// Reads 256-bit words from frame_fifo, which runs in normal (non-showahead)
// mode. Each word is split into eight 32-bit pixels, lane 0 first. The pixels
// leave on a valid/ready stream tagged with start-of-frame and end-of-line.
//
// Ports
//   clk           single clock, shared with the frame_fifo read side
//   rst_n         asynchronous active-low reset
//   fifo_q        frame_fifo read data, valid the cycle after fifo_rdreq
//   fifo_rdempty  frame_fifo read-side empty flag
//   fifo_rdreq    frame_fifo read request
//   pix_data      current pixel (lane k = bits [32k+31:32k])
//   pix_valid     pix_data valid
//   pix_ready     downstream accepts; a transfer is pix_valid && pix_ready
//   pix_sof       marks pixel (0,0) of a frame
//   pix_eol       marks the last pixel of each line
//   underflow     sticky; the stream was starved in the middle of a frame

module frame_fifo_unpacker #(
   parameter int H_PIXELS = 1920,
   parameter int V_LINES  = 1080
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [255:0] fifo_q,
   input  logic         fifo_rdempty,
   output logic         fifo_rdreq,
   output logic [31:0]  pix_data,
   output logic         pix_valid,
   input  logic         pix_ready,
   output logic         pix_sof,
   output logic         pix_eol,
   output logic         underflow
);

   localparam int XW = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1;
   localparam int YW = (V_LINES > 1) ? $clog2(V_LINES) : 1;
   localparam logic [XW-1:0] X_LAST = XW'(H_PIXELS - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(V_LINES - 1);

   logic [255:0]  nxt_word_q, nxt_word_d;
   logic [255:0]  cur_word_q, cur_word_d;
   logic          nxt_valid_q, nxt_valid_d;
   logic          req_pend_q, req_pend_d;
   logic [2:0]    lane_q, lane_d;
   logic [XW-1:0] x_q, x_d;
   logic [YW-1:0] y_q, y_d;
   logic [31:0]   pix_data_q, pix_data_d;
   logic          pix_valid_q, pix_valid_d;
   logic          pix_sof_q, pix_sof_d;
   logic          pix_eol_q, pix_eol_d;
   logic          underflow_q, underflow_d;

   logic          rdreq;
   logic          xfer;
   logic          src_avail;
   logic [255:0]  src_word;
   logic          load;
   logic [2:0]    lane_inc;

   // Handshake decode. At most one word is ever in flight or prefetched, so
   // nxt_valid and req_pend are never both set. A word landing on fifo_q this
   // cycle can therefore go straight into the current word. That bypass is
   // what gives a two-edge latency from fifo_rdreq to pix_valid. The read
   // request is gated by rst_n so it drops the moment reset is asserted.
   always_comb begin
      rdreq     = rst_n && !fifo_rdempty && !nxt_valid_q && !req_pend_q;
      xfer      = pix_valid_q && pix_ready;
      src_avail = nxt_valid_q || req_pend_q;
      src_word  = nxt_valid_q ? nxt_word_q : fifo_q;
      load      = src_avail && (!pix_valid_q || (xfer && (lane_q == 3'd7)));
      lane_inc  = lane_q + 3'd1;
   end

   // Next-state logic for the prefetch slot, the current word and lane, the
   // x/y position and the registered pixel outputs. x/y always hold the
   // coordinates of the pixel being presented, or of the next pixel expected
   // while starved. This lets the stream resume at the same position after a
   // gap.
   always_comb begin
      nxt_word_d  = nxt_word_q;
      nxt_valid_d = nxt_valid_q;
      req_pend_d  = rdreq;
      cur_word_d  = cur_word_q;
      lane_d      = lane_q;
      x_d         = x_q;
      y_d         = y_q;
      pix_data_d  = pix_data_q;
      pix_valid_d = pix_valid_q;

      if (load && nxt_valid_q) begin
         nxt_valid_d = 1'b0;
      end
      // A landing word is parked in the prefetch slot unless the bypass
      // consumed it directly.
      if (req_pend_q && !(load && !nxt_valid_q)) begin
         nxt_word_d  = fifo_q;
         nxt_valid_d = 1'b1;
      end

      if (xfer) begin
         if (x_q == X_LAST) begin
            x_d = '0;
            y_d = (y_q == Y_LAST) ? '0 : y_q + YW'(1);
         end else begin
            x_d = x_q + XW'(1);
         end
      end

      if (load) begin
         cur_word_d  = src_word;
         lane_d      = 3'd0;
         pix_data_d  = src_word[31:0];
         pix_valid_d = 1'b1;
      end else if (xfer) begin
         lane_d = lane_inc;
         if (lane_q == 3'd7) begin
            pix_valid_d = 1'b0;
         end else begin
            pix_data_d = cur_word_q[{lane_inc, 5'd0} +: 32];
         end
      end

      pix_sof_d   = pix_valid_d && (x_d == '0) && (y_d == '0);
      pix_eol_d   = pix_valid_d && (x_d == X_LAST);
      underflow_d = underflow_q ||
                    (pix_ready && !pix_valid_q && ((x_q != '0) || (y_q != '0)));
   end

   // Control and output registers. All of them clear asynchronously. Clearing
   // req_pend drops any read in flight, so its data is never presented.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         nxt_valid_q <= 1'b0;
         req_pend_q  <= 1'b0;
         lane_q      <= 3'd0;
         x_q         <= '0;
         y_q         <= '0;
         pix_data_q  <= '0;
         pix_valid_q <= 1'b0;
         pix_sof_q   <= 1'b0;
         pix_eol_q   <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         nxt_valid_q <= nxt_valid_d;
         req_pend_q  <= req_pend_d;
         lane_q      <= lane_d;
         x_q         <= x_d;
         y_q         <= y_d;
         pix_data_q  <= pix_data_d;
         pix_valid_q <= pix_valid_d;
         pix_sof_q   <= pix_sof_d;
         pix_eol_q   <= pix_eol_d;
         underflow_q <= underflow_d;
      end
   end

   // The wide word registers need no reset. Their contents are only
   // meaningful while the matching valid flag is set.
   always_ff @(posedge clk) begin
      nxt_word_q <= nxt_word_d;
      cur_word_q <= cur_word_d;
   end

   assign fifo_rdreq = rdreq;
   assign pix_data   = pix_data_q;
   assign pix_valid  = pix_valid_q;
   assign pix_sof    = pix_sof_q;
   assign pix_eol    = pix_eol_q;
   assign underflow  = underflow_q;

endmodule

// File: tb/tb_frame_fifo_unpacker.sv
// tb_frame_fifo_unpacker
// Bench for frame_fifo_unpacker using a 16x2 frame. A queue models the
// non-showahead frame_fifo. Every pushed word queues eight expected pixels,
// each with its own sof/eol flags, and a monitor pops and compares them as
// they transfer. A short table checks the first word cycle by cycle.

module tb_frame_fifo_unpacker;

   localparam int H        = 16;
   localparam int V        = 2;
   localparam int MAX_WAIT = 5000;

   typedef struct {
      logic [31:0] data;
      logic        sof;
      logic        eol;
   } pixExp_t;

   typedef struct {
      logic        ready;
      logic        expValid;
      logic [31:0] expData;
      logic        expSof;
      logic        expEol;
      logic        expRdreq;
   } vector_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [255:0] fifo_q = '0;
   logic         fifo_rdempty = 1'b1;
   logic         fifo_rdreq;
   logic [31:0]  pix_data;
   logic         pix_valid;
   logic         pix_ready = 1'b0;
   logic         pix_sof;
   logic         pix_eol;
   logic         underflow;

   int           checks = 0;
   int           errors = 0;
   logic [255:0] fifoMem[$];
   pixExp_t      sbQueue[$];
   int           expX = 0;
   int           expY = 0;
   int unsigned  dataSeed = 0;
   bit           gapCheck = 1'b0;
   int           gapCount = 0;
   int           rdreqViolations = 0;
   int           sofCount = 0;
   int           eolCount = 0;
   int           xferCount = 0;
   logic         stallPrev = 1'b0;
   logic         prevRdreq = 1'b0;
   logic [31:0]  prevData = '0;
   logic         prevSof = 1'b0;
   logic         prevEol = 1'b0;
   vector_t      vectors[13];

   // Free-running 10 ns clock.
   always #5 clk = ~clk;

   frame_fifo_unpacker #(.H_PIXELS(H), .V_LINES(V)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .fifo_q       (fifo_q),
      .fifo_rdempty (fifo_rdempty),
      .fifo_rdreq   (fifo_rdreq),
      .pix_data     (pix_data),
      .pix_valid    (pix_valid),
      .pix_ready    (pix_ready),
      .pix_sof      (pix_sof),
      .pix_eol      (pix_eol),
      .underflow    (underflow)
   );

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Queue a number of words in the FIFO model and the matching pixels in the
   // scoreboard. Each pixel carries the next value of a running counter and
   // the sof/eol flags given by the bench's own x/y position.
   task automatic pushWords(input int count);
      logic [255:0] w;
      pixExp_t      e;
      for (int n = 0; n < count; n++) begin
         for (int k = 0; k < 8; k++) begin
            e.data = dataSeed;
            e.sof  = (expX == 0) && (expY == 0);
            e.eol  = (expX == H - 1);
            w[k*32 +: 32] = dataSeed;
            sbQueue.push_back(e);
            dataSeed++;
            if (expX == H - 1) begin
               expX = 0;
               expY = (expY == V - 1) ? 0 : expY + 1;
            end else begin
               expX++;
            end
         end
         fifoMem.push_back(w);
      end
   endtask

   task automatic stepCycle(input bit randomReady);
      @(posedge clk);
      #1;
      pix_ready = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
   endtask

   task automatic applyStimulus(input vector_t v);
      @(posedge clk);
      #1;
      pix_ready = v.ready;
      @(negedge clk);
   endtask

   task automatic drain(input string name, input bit randomReady);
      int n = 0;
      while (sbQueue.size() != 0 && n < MAX_WAIT) begin
         stepCycle(randomReady);
         n++;
      end
      pix_ready = 1'b1;
      checkOutput(name, 32'(sbQueue.size()), 32'd0);
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_valid"}, {31'd0, pix_valid}, 32'd0);
      checkOutput({tag, "_sof"}, {31'd0, pix_sof}, 32'd0);
      checkOutput({tag, "_eol"}, {31'd0, pix_eol}, 32'd0);
      checkOutput({tag, "_underflow"}, {31'd0, underflow}, 32'd0);
      checkOutput({tag, "_rdreq"}, {31'd0, fifo_rdreq}, 32'd0);
      checkOutput({tag, "_data"}, pix_data, 32'd0);
   endtask

   // FIFO model. A read sampled at a rising edge presents its word on fifo_q
   // after that edge. The empty flag is also updated on the edge.
   always @(posedge clk) begin
      if (fifo_rdreq && fifoMem.size() != 0) begin
         fifo_q <= fifoMem.pop_front();
      end
      fifo_rdempty <= (fifoMem.size() == 0);
   end

   // Monitor, sampled on the falling edge. It checks that a stalled pixel
   // stays frozen and scores every transfer against the scoreboard. It also
   // counts read-request protocol violations and pix_valid gaps during the
   // streaming test.
   always @(negedge clk) begin : monitorBlk
      pixExp_t e;
      if (!rst_n) begin
         stallPrev = 1'b0;
         prevRdreq = 1'b0;
      end else begin
         if (stallPrev) begin
            checkOutput("stall_valid", {31'd0, pix_valid}, 32'd1);
            checkOutput("stall_data", pix_data, prevData);
            checkOutput("stall_flags", {30'd0, pix_sof, pix_eol}, {30'd0, prevSof, prevEol});
         end
         if (fifo_rdreq && (fifo_rdempty || prevRdreq)) rdreqViolations++;
         if (gapCheck && sbQueue.size() != 0 && !pix_valid) gapCount++;
         if (pix_valid && pix_ready) begin
            xferCount++;
            if (pix_sof) sofCount++;
            if (pix_eol) eolCount++;
            if (sbQueue.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_pixel: got 0x%0h, expected no pixel", pix_data);
            end else begin
               e = sbQueue.pop_front();
               checkOutput("pixel_data", pix_data, e.data);
               checkOutput("pixel_flags", {30'd0, pix_sof, pix_eol}, {30'd0, e.sof, e.eol});
            end
         end
         stallPrev = pix_valid && !pix_ready;
         prevData  = pix_data;
         prevSof   = pix_sof;
         prevEol   = pix_eol;
         prevRdreq = fifo_rdreq;
      end
   end

   // Hard stop in case something hangs outside the bounded waits.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main test sequence.
   initial begin
      int n;
      int xferStart;
      logic [31:0] firstData;

      // Cycle-exact expectations for the first word (lanes 0..7 = 0..7).
      // Step 0 is the cycle right after the read request.
      vectors[0] = '{1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0};
      vectors[1] = '{1'b1, 1'b1, 32'd0, 1'b1, 1'b0, 1'b1};
      for (int i = 2; i <= 8; i++) begin
         vectors[i] = '{1'b1, 1'b1, 32'(i - 1), 1'b0, 1'b0, 1'b0};
      end
      vectors[9]  = '{1'b0, 1'b1, 32'd8, 1'b0, 1'b0, 1'b1};
      vectors[10] = '{1'b0, 1'b1, 32'd8, 1'b0, 1'b0, 1'b0};
      vectors[11] = '{1'b1, 1'b1, 32'd8, 1'b0, 1'b0, 1'b0};
      vectors[12] = '{1'b1, 1'b1, 32'd9, 1'b0, 1'b0, 1'b0};

      // Reset state.
      #1;
      checkAllZero("reset");
      repeat (3) @(posedge clk);
      #1;
      rst_n     = 1'b1;
      pix_ready = 1'b1;

      // First word, latency and a short stall, driven from the table.
      pushWords(4);
      n = 0;
      while (!fifo_rdreq && n < 20) begin
         @(negedge clk);
         n++;
      end
      checkOutput("first_rdreq", {31'd0, fifo_rdreq}, 32'd1);
      for (int i = 0; i < 13; i++) begin
         applyStimulus(vectors[i]);
         checkOutput($sformatf("vec%0d_valid", i), {31'd0, pix_valid}, {31'd0, vectors[i].expValid});
         checkOutput($sformatf("vec%0d_data", i), pix_data, vectors[i].expData);
         checkOutput($sformatf("vec%0d_sof", i), {31'd0, pix_sof}, {31'd0, vectors[i].expSof});
         checkOutput($sformatf("vec%0d_eol", i), {31'd0, pix_eol}, {31'd0, vectors[i].expEol});
         checkOutput($sformatf("vec%0d_rdreq", i), {31'd0, fifo_rdreq}, {31'd0, vectors[i].expRdreq});
      end
      drain("frame1_drain", 1'b0);

      // FIFO empty at the frame boundary is not an underflow.
      for (int i = 0; i < 20; i++) stepCycle(1'b0);
      checkOutput("boundary_underflow", {31'd0, underflow}, 32'd0);
      checkOutput("boundary_valid", {31'd0, pix_valid}, 32'd0);

      // 256 prefilled words stream with no bubbles and one read in flight.
      xferStart = xferCount;
      pushWords(256);
      n = 0;
      while (!pix_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      checkOutput("stream_start", {31'd0, pix_valid}, 32'd1);
      gapCheck = 1'b1;
      drain("stream_drain", 1'b0);
      gapCheck = 1'b0;
      checkOutput("stream_gaps", 32'(gapCount), 32'd0);
      checkOutput("stream_count", 32'(xferCount - xferStart), 32'd2048);
      checkOutput("rdreq_protocol", 32'(rdreqViolations), 32'd0);
      checkOutput("stream_underflow", {31'd0, underflow}, 32'd0);

      // Random back-pressure over two frames.
      sofCount = 0;
      eolCount = 0;
      pushWords(8);
      drain("random_drain", 1'b1);
      checkOutput("random_sof_count", 32'(sofCount), 32'd2);
      checkOutput("random_eol_count", 32'(eolCount), 32'd4);
      checkOutput("random_underflow", {31'd0, underflow}, 32'd0);

      // Starvation mid-frame. The scoreboard checks the resume at pixel 8.
      pushWords(1);
      drain("starve_drain", 1'b0);
      for (int i = 0; i < 5; i++) stepCycle(1'b0);
      checkOutput("starve_underflow", {31'd0, underflow}, 32'd1);
      checkOutput("starve_valid", {31'd0, pix_valid}, 32'd0);
      pushWords(3);
      drain("resume_drain", 1'b0);
      checkOutput("resume_underflow", {31'd0, underflow}, 32'd1);

      // Reset mid-line while the third word's read is in flight.
      pushWords(3);
      n = 0;
      while (!(fifo_rdreq && pix_valid && !pix_sof) && n < 100) begin
         @(negedge clk);
         n++;
      end
      checkOutput("midline_rdreq", {31'd0, fifo_rdreq && pix_valid && !pix_sof}, 32'd1);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      checkAllZero("midreset");
      sbQueue.delete();
      expX = 0;
      expY = 0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      firstData = dataSeed;
      pushWords(4);
      n = 0;
      while (!pix_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      checkOutput("after_reset_valid", {31'd0, pix_valid}, 32'd1);
      checkOutput("after_reset_sof", {31'd0, pix_sof}, 32'd1);
      checkOutput("after_reset_data", pix_data, firstData);
      drain("after_reset_drain", 1'b0);
      checkOutput("after_reset_underflow", {31'd0, underflow}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
